// File: rtl/pipeline_hazard_ctrl_pkg.sv
// pipeline_hazard_ctrl_pkg: shared encodings, opcode constants and controller state type
package pipeline_hazard_ctrl_pkg;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J = 6'h02;
  localparam logic [5:0] OP_JAL = 6'h03;
  localparam logic [5:0] OP_BNE = 6'h05;
  localparam logic [5:0] OP_LW = 6'h23;
  localparam logic [5:0] FUNC_JR = 6'h08;
  localparam logic [5:0] FUNC_SYSCALL = 6'h0c;
  localparam logic [1:0] PC_SEL_SEQ = 2'd0;
  localparam logic [1:0] PC_SEL_JUMP = 2'd1;
  localparam logic [1:0] PC_SEL_REDIR = 2'd2;
  localparam logic [1:0] FWD_RF = 2'd0;
  localparam logic [1:0] FWD_MEM = 2'd1;
  localparam logic [1:0] FWD_WB = 2'd2;
  typedef enum logic [1:0] {RUN, DRAIN, HALT} ctrl_state_t;
endpackage

// File: rtl/pipeline_hazard_ctrl_fwd.sv
// forwarding_unit: picks the newest in-flight producer of one EX operand register
module forwarding_unit
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int RA_W = 5
) (
  input  logic [RA_W-1:0] src,
  input  logic            mem_reg_write,
  input  logic [RA_W-1:0] mem_dest,
  input  logic            wb_reg_write,
  input  logic [RA_W-1:0] wb_dest,
  output logic [1:0]      sel
);
  always_comb
    sel = (mem_reg_write && mem_dest == src && src != '0) ? FWD_MEM :
          (wb_reg_write && wb_dest == src && src != '0) ? FWD_WB : FWD_RF;
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush/redirect arbitration, operand forwarding and SYSCALL drain-to-halt
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int RA_W = 5,
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [RA_W-1:0]  id_rs,
  input  logic [RA_W-1:0]  id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             id_jump,
  input  logic             id_syscall,
  input  logic             ex_valid,
  input  logic             ex_mem_read,
  input  logic             ex_reg_write,
  input  logic [RA_W-1:0]  ex_dest,
  input  logic             ex_redirect,
  input  logic             mem_reg_write,
  input  logic [RA_W-1:0]  mem_dest,
  input  logic             wb_reg_write,
  input  logic [RA_W-1:0]  wb_dest,
  output logic             pc_we,
  output logic [1:0]       pc_sel,
  output logic             ifid_we,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic             halted,
  output logic [CNT_W-1:0] stall_count
);
  localparam int DW = DRAIN_CYCLES > 1 ? $clog2(DRAIN_CYCLES) + 1 : 1;
  ctrl_state_t state, state_n;
  logic [DW-1:0] cnt, cnt_n;
  logic stall_inc, load_use, ex_reg_write_unused;
  logic [1:0] fwd_a_raw, fwd_b_raw;
  assign ex_reg_write_unused = ex_reg_write;
  assign load_use = ex_valid && ex_mem_read && ex_dest != '0 && id_valid &&
                    ((id_uses_rs && id_rs == ex_dest) || (id_uses_rt && id_rt == ex_dest));
  forwarding_unit #(.RA_W(RA_W)) u_fwd_a (
    .src(id_rs), .mem_reg_write(mem_reg_write), .mem_dest(mem_dest),
    .wb_reg_write(wb_reg_write), .wb_dest(wb_dest), .sel(fwd_a_raw)
  );
  forwarding_unit #(.RA_W(RA_W)) u_fwd_b (
    .src(id_rt), .mem_reg_write(mem_reg_write), .mem_dest(mem_dest),
    .wb_reg_write(wb_reg_write), .wb_dest(wb_dest), .sel(fwd_b_raw)
  );
  assign fwd_a_sel = reset ? FWD_RF : fwd_a_raw;
  assign fwd_b_sel = reset ? FWD_RF : fwd_b_raw;
  assign halted = state == HALT;
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    pc_we = 1'b0;
    pc_sel = PC_SEL_SEQ;
    ifid_we = 1'b0;
    ifid_flush = 1'b0;
    idex_bubble = 1'b0;
    stall_inc = 1'b0;
    if (reset) begin
      ifid_flush = 1'b1;
      idex_bubble = 1'b1;
    end else begin
      case (state)
        RUN:
          if (ex_redirect) begin
            pc_sel = PC_SEL_REDIR;
            pc_we = 1'b1;
            ifid_flush = 1'b1;
            idex_bubble = 1'b1;
          end else if (load_use) begin
            idex_bubble = 1'b1;
            stall_inc = 1'b1;
          end else if (id_jump && id_valid) begin
            pc_sel = PC_SEL_JUMP;
            pc_we = 1'b1;
            ifid_flush = 1'b1;
          end else if (id_syscall && id_valid) begin
            ifid_flush = 1'b1;
            idex_bubble = 1'b1;
            state_n = DRAIN;
            cnt_n = '0;
          end else begin
            pc_we = 1'b1;
            ifid_we = 1'b1;
          end
        DRAIN: begin
          ifid_flush = 1'b1;
          idex_bubble = 1'b1;
          cnt_n = cnt + 1'b1;
          state_n = cnt == DW'(DRAIN_CYCLES - 1) ? HALT : DRAIN;
        end
        default: ;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
      cnt <= '0;
      stall_count <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      if (stall_inc && !(&stall_count)) stall_count <= stall_count + 1'b1;
    end
  end
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed self-checking bench for the hazard controller
module tb_pipeline_hazard_ctrl;
  logic clk = 0, reset;
  logic id_valid, id_uses_rs, id_uses_rt, id_jump, id_syscall;
  logic [4:0] id_rs, id_rt, ex_dest, mem_dest, wb_dest;
  logic ex_valid, ex_mem_read, ex_reg_write, ex_redirect, mem_reg_write, wb_reg_write;
  logic pc_we, ifid_we, ifid_flush, idex_bubble, halted;
  logic [1:0] pc_sel, fwd_a_sel, fwd_b_sel;
  logic [15:0] stall_count;
  int total = 0, bad = 0;
  pipeline_hazard_ctrl dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_jump(id_jump), .id_syscall(id_syscall),
    .ex_valid(ex_valid), .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write), .ex_dest(ex_dest),
    .ex_redirect(ex_redirect), .mem_reg_write(mem_reg_write), .mem_dest(mem_dest),
    .wb_reg_write(wb_reg_write), .wb_dest(wb_dest), .pc_we(pc_we), .pc_sel(pc_sel),
    .ifid_we(ifid_we), .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .halted(halted), .stall_count(stall_count)
  );
  always #5 clk = ~clk;
  task automatic idle();
    id_valid = 0; id_rs = 0; id_rt = 0; id_uses_rs = 0; id_uses_rt = 0; id_jump = 0; id_syscall = 0;
    ex_valid = 0; ex_mem_read = 0; ex_reg_write = 0; ex_dest = 0; ex_redirect = 0;
    mem_reg_write = 0; mem_dest = 0; wb_reg_write = 0; wb_dest = 0;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic set_load_use();
    ex_valid = 1; ex_mem_read = 1; ex_reg_write = 1; ex_dest = 8;
    id_valid = 1; id_uses_rs = 1; id_rs = 8;
  endtask
  task automatic test_reset();
    idle();
    reset = 1;
    tick(); tick();
    #1;
    total++; if (pc_we !== 0) begin bad++; $display("FAIL reset_pc_we got=%0d want=0", pc_we); end
    total++; if (ifid_flush !== 1 || idex_bubble !== 1) begin bad++; $display("FAIL reset_flush got=%0d%0d want=11", ifid_flush, idex_bubble); end
    total++; if (halted !== 0 || stall_count !== 0) begin bad++; $display("FAIL reset_state got=%0d/%0h want=0/0", halted, stall_count); end
    reset = 0;
    tick();
    #1;
    total++; if (pc_we !== 1 || ifid_we !== 1 || pc_sel !== 0) begin bad++; $display("FAIL run_idle got=%0d%0d%0d want=110", pc_we, ifid_we, pc_sel); end
  endtask
  task automatic test_load_use();
    idle(); set_load_use();
    #1;
    total++; if (pc_we !== 0 || ifid_we !== 0 || idex_bubble !== 1) begin bad++; $display("FAIL load_use_stall got=%0d%0d%0d want=001", pc_we, ifid_we, idex_bubble); end
    total++; if (stall_count !== 0) begin bad++; $display("FAIL load_use_cnt0 got=%0h want=0", stall_count); end
    tick();
    idle(); id_valid = 1; id_uses_rs = 1; id_rs = 8; ex_valid = 1; ex_reg_write = 1; ex_dest = 8;
    #1;
    total++; if (stall_count !== 1) begin bad++; $display("FAIL load_use_cnt1 got=%0h want=1", stall_count); end
    total++; if (pc_we !== 1 || idex_bubble !== 0) begin bad++; $display("FAIL load_use_resume got=%0d%0d want=10", pc_we, idex_bubble); end
    tick();
  endtask
  task automatic test_load_r0();
    idle();
    ex_valid = 1; ex_mem_read = 1; ex_dest = 0; id_valid = 1; id_uses_rs = 1; id_rs = 0;
    mem_reg_write = 1; mem_dest = 0;
    #1;
    total++; if (pc_we !== 1 || idex_bubble !== 0) begin bad++; $display("FAIL r0_no_stall got=%0d%0d want=10", pc_we, idex_bubble); end
    total++; if (fwd_a_sel !== 0) begin bad++; $display("FAIL r0_fwd got=%0d want=0", fwd_a_sel); end
    tick();
  endtask
  task automatic test_forwarding();
    idle();
    id_rs = 9; id_rt = 9; mem_reg_write = 1; mem_dest = 9; wb_reg_write = 1; wb_dest = 9;
    #1;
    total++; if (fwd_a_sel !== 1 || fwd_b_sel !== 1) begin bad++; $display("FAIL fwd_mem_prio got=%0d/%0d want=1/1", fwd_a_sel, fwd_b_sel); end
    mem_reg_write = 0;
    #1;
    total++; if (fwd_a_sel !== 2) begin bad++; $display("FAIL fwd_wb got=%0d want=2", fwd_a_sel); end
    id_rt = 4; mem_reg_write = 1; mem_dest = 4;
    #1;
    total++; if (fwd_a_sel !== 2 || fwd_b_sel !== 1) begin bad++; $display("FAIL fwd_split got=%0d/%0d want=2/1", fwd_a_sel, fwd_b_sel); end
    wb_reg_write = 0;
    #1;
    total++; if (fwd_a_sel !== 0) begin bad++; $display("FAIL fwd_none got=%0d want=0", fwd_a_sel); end
    tick();
  endtask
  task automatic test_jump();
    idle(); id_valid = 1; id_jump = 1;
    #1;
    total++; if (pc_sel !== 1 || pc_we !== 1 || ifid_flush !== 1 || idex_bubble !== 0) begin bad++; $display("FAIL jump got=%0d%0d%0d%0d want=1110", pc_sel, pc_we, ifid_flush, idex_bubble); end
    tick();
  endtask
  task automatic test_redirect();
    idle(); set_load_use(); id_jump = 1; ex_redirect = 1;
    #1;
    total++; if (pc_sel !== 2 || pc_we !== 1 || ifid_flush !== 1 || idex_bubble !== 1) begin bad++; $display("FAIL redirect got=%0d%0d%0d%0d want=2111", pc_sel, pc_we, ifid_flush, idex_bubble); end
    tick();
    idle();
    #1;
    total++; if (stall_count !== 1) begin bad++; $display("FAIL redirect_cnt got=%0h want=1", stall_count); end
  endtask
  task automatic test_syscall();
    idle(); id_valid = 1; id_syscall = 1;
    #1;
    total++; if (pc_we !== 0 || ifid_flush !== 1 || idex_bubble !== 1) begin bad++; $display("FAIL syscall got=%0d%0d%0d want=011", pc_we, ifid_flush, idex_bubble); end
    tick();
    idle(); ex_redirect = 1;
    #1;
    total++; if (pc_sel !== 0 || pc_we !== 0 || halted !== 0) begin bad++; $display("FAIL drain1 got=%0d%0d%0d want=000", pc_sel, pc_we, halted); end
    tick(); tick();
    total++; if (halted !== 0 || ifid_flush !== 1) begin bad++; $display("FAIL drain3 got=%0d%0d want=01", halted, ifid_flush); end
    tick();
    total++; if (halted !== 1) begin bad++; $display("FAIL halt_edge4 got=%0d want=1", halted); end
    idle(); tick(); tick();
    total++; if (halted !== 1 || pc_we !== 0 || ifid_we !== 0) begin bad++; $display("FAIL halt_hold got=%0d%0d%0d want=100", halted, pc_we, ifid_we); end
    reset = 1;
    #1;
    total++; if (ifid_flush !== 1 || idex_bubble !== 1 || pc_we !== 0) begin bad++; $display("FAIL halt_reset_force got=%0d%0d%0d want=110", ifid_flush, idex_bubble, pc_we); end
    tick();
    reset = 0;
    #1;
    total++; if (halted !== 0 || pc_we !== 1 || stall_count !== 0) begin bad++; $display("FAIL halt_exit got=%0d%0d/%0h want=01/0", halted, pc_we, stall_count); end
  endtask
  task automatic test_saturate();
    idle(); set_load_use();
    repeat (65540) tick();
    total++; if (stall_count !== 16'hFFFF) begin bad++; $display("FAIL saturate got=%0h want=ffff", stall_count); end
    total++; if (pc_we !== 0 || idex_bubble !== 1) begin bad++; $display("FAIL saturate_stall got=%0d%0d want=01", pc_we, idex_bubble); end
  endtask
  initial begin
    test_reset();
    test_load_use();
    test_load_r0();
    test_forwarding();
    test_jump();
    test_redirect();
    test_syscall();
    test_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
